// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared encodings for the data-memory responder.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Byte-lane mask, store replication, load extraction/extension.
// Revision : 1.0
// ============================================================================
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rword >> {i_addr_lo, 3'b000};

  always_comb begin
    o_mask     = 4'b0000;
    o_wdata    = 32'h0;
    o_rdata    = 32'h0;
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_mask  = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_unsigned ? {24'h0, w_shifted[7:0]}
                             : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_HALF: begin
        o_misalign = i_addr_lo[0];
        o_mask     = 4'b0011 << i_addr_lo;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = i_unsigned ? {16'h0, w_shifted[15:0]}
                                : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      SZ_WORD: begin
        o_misalign = |i_addr_lo;
        o_mask     = 4'b1111;
        o_wdata    = i_wdata;
        o_rdata    = w_shifted;
      end
      default: begin
        o_misalign = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : MEM-stage load/store target with programmable access latency.
// Revision : 1.0
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_busy
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_write;
  logic               r_unsigned;
  logic [1:0]         r_size;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_resp_valid;
  logic               r_resp_err;
  logic [31:0]        r_resp_rdata;
  logic [31:0]        r_mem [0:DEPTH-1];

  logic               w_accept;
  logic               w_access;
  logic [IDX_W-1:0]   w_idx;
  logic               w_oob;
  logic               w_err;
  logic [31:0]        w_rword;
  logic [3:0]         w_mask;
  logic [31:0]        w_wdata_al;
  logic [31:0]        w_rdata_ext;
  logic               w_misalign;

  assign w_accept = i_req_valid && (r_state == ST_IDLE);
  assign w_access = (r_state == ST_WAIT) && (r_cnt == '0);
  assign w_idx    = r_addr[IDX_W+1:2];
  assign w_oob    = |r_addr[31:IDX_W+2];
  assign w_rword  = r_mem[w_idx];
  assign w_err    = w_misalign || w_oob;

  dmem_lane_align u_align (
    .i_size     (r_size),
    .i_addr_lo  (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rword    (w_rword),
    .o_mask     (w_mask),
    .o_wdata    (w_wdata_al),
    .o_rdata    (w_rdata_ext),
    .o_misalign (w_misalign)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)      w_next = ST_WAIT;
      ST_WAIT: if (r_cnt == '0)   w_next = ST_RESP;
      ST_RESP:                    w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= SZ_BYTE;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write    <= i_req_write;
        r_unsigned <= i_req_unsigned;
        r_size     <= i_req_size;
        r_addr     <= i_req_addr;
        r_wdata    <= i_req_wdata;
        r_cnt      <= CNT_W'(LATENCY - 1);
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Response registers load on the WAIT->RESP edge and hold through RESP.
      if (w_access) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= (!r_write && !w_err) ? w_rdata_ext : 32'h0;
      end else begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  // Storage is not reset; an async reset forces IDLE, which blocks the write.
  always_ff @(posedge clk) begin
    if (w_access && r_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_al[8*b +: 8];
      end
    end
  end

  assign o_req_ready  = (r_state == ST_IDLE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder.
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk;
  logic        rst_n;
  logic        r_req_valid;
  logic        w_req_ready;
  logic        r_req_write;
  logic [1:0]  r_req_size;
  logic        r_req_unsigned;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic        w_resp_valid;
  logic [31:0] w_resp_rdata;
  logic        w_resp_err;
  logic        w_busy;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (r_req_valid),
    .o_req_ready    (w_req_ready),
    .i_req_write    (r_req_write),
    .i_req_size     (r_req_size),
    .i_req_unsigned (r_req_unsigned),
    .i_req_addr     (r_req_addr),
    .i_req_wdata    (r_req_wdata),
    .o_resp_valid   (w_resp_valid),
    .o_resp_rdata   (w_resp_rdata),
    .o_resp_err     (w_resp_err),
    .o_busy         (w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction: accept, latency count, response contents, return to IDLE.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    int cyc;
    @(negedge clk);
    r_req_valid    = 1'b1;
    r_req_write    = w;
    r_req_size     = sz;
    r_req_unsigned = u;
    r_req_addr     = a;
    r_req_wdata    = wd;
    #1;
    check({tag, "_ready"}, {31'h0, w_req_ready}, 32'h1);
    @(posedge clk);
    #1;
    r_req_valid = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      if (w_resp_valid) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, LATENCY);
    check({tag, "_rd"},  w_resp_rdata, exp_rd);
    check({tag, "_err"}, {31'h0, w_resp_err}, {31'h0, exp_err});
    check({tag, "_busy"}, {31'h0, w_busy}, 32'h1);
    @(posedge clk);
    #1;
    check({tag, "_rvoff"}, {31'h0, w_resp_valid}, 32'h0);
    check({tag, "_idle"}, {31'h0, w_req_ready}, 32'h1);
  endtask

  initial begin
    rst_n          = 1'b0;
    r_req_valid    = 1'b0;
    r_req_write    = 1'b0;
    r_req_size     = SZ_WORD;
    r_req_unsigned = 1'b0;
    r_req_addr     = 32'h0;
    r_req_wdata    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", {31'h0, w_req_ready},  32'h1);
    check("rst_rv",    {31'h0, w_resp_valid}, 32'h0);
    check("rst_rd",    w_resp_rdata,          32'h0);
    check("rst_err",   {31'h0, w_resp_err},   32'h0);
    check("rst_busy",  {31'h0, w_busy},       32'h0);

    do_req("sw10",  1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("lw10",  1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    do_req("sw10z", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    do_req("sb13",  1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h00000080, 32'h0, 1'b0);
    do_req("lb13",  1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req("lbu13", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0);
    do_req("lw10b", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h80000000, 1'b0);

    do_req("sw20z", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    do_req("sh22",  1'b1, SZ_HALF, 1'b0, 32'h22, 32'h00001234, 32'h0, 1'b0);
    do_req("lh22",  1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'h00001234, 1'b0);
    do_req("sh20",  1'b1, SZ_HALF, 1'b0, 32'h20, 32'h5555ABCD, 32'h0, 1'b0);
    do_req("lh20",  1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 32'hFFFFABCD, 1'b0);
    do_req("lhu20", 1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, 32'h0000ABCD, 1'b0);
    do_req("lw20",  1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h1234ABCD, 1'b0);
    do_req("lh21",  1'b0, SZ_HALF, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1);
    do_req("sh21",  1'b1, SZ_HALF, 1'b0, 32'h21, 32'h0000FFFF, 32'h0, 1'b1);
    do_req("sw22",  1'b1, SZ_WORD, 1'b0, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_req("lw20b", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h1234ABCD, 1'b0);

    do_req("lwoob", 1'b0, SZ_WORD, 1'b0, DEPTH * 4, 32'h0, 32'h0, 1'b1);
    do_req("lwlast",1'b0, SZ_WORD, 1'b0, DEPTH * 4 - 4, 32'h0, 32'h0, 1'b0);
    do_req("s11",   1'b1, SZ_ILL,  1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_req("lw10c", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h80000000, 1'b0);

    // Reset asserted while a store sits in WAIT.
    do_req("sw40",  1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11111111, 32'h0, 1'b0);
    @(negedge clk);
    r_req_valid = 1'b1;
    r_req_write = 1'b1;
    r_req_size  = SZ_WORD;
    r_req_addr  = 32'h40;
    r_req_wdata = 32'h22222222;
    @(posedge clk);
    #1;
    r_req_valid = 1'b0;
    check("mid_busy", {31'h0, w_busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_ready", {31'h0, w_req_ready},  32'h1);
    check("mr_rv",    {31'h0, w_resp_valid}, 32'h0);
    check("mr_busy",  {31'h0, w_busy},       32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("mr_hold_rv", {31'h0, w_resp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req("lw40",  1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h11111111, 1'b0);

    // Continuous request: IDLE, WAIT x LATENCY, RESP repeating.
    @(negedge clk);
    r_req_valid    = 1'b1;
    r_req_write    = 1'b0;
    r_req_size     = SZ_WORD;
    r_req_unsigned = 1'b0;
    r_req_addr     = 32'h10;
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("cv_ready%0d", i), {31'h0, w_req_ready},
            {31'h0, (i % 4) == 0});
      check($sformatf("cv_busy%0d", i), {31'h0, w_busy},
            {31'h0, (i % 4) != 0});
      check($sformatf("cv_rv%0d", i), {31'h0, w_resp_valid},
            {31'h0, (i % 4) == 3});
      if ((i % 4) == 3) check($sformatf("cv_rd%0d", i), w_resp_rdata, 32'h80000000);
      if (i < 11) @(negedge clk);
    end
    r_req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("cv_end_ready", {31'h0, w_req_ready}, 32'h1);
    @(posedge clk);
    #1;
    check("cv_end_idle", {31'h0, w_busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
